ksq_sequencer: RTL and testbench

Step sequencer for the repeated-squaring / multiply chain used in field inversion. It walks the square-count ROM one address at a time and, for each step, emits a burst of single-cycle squaring enables followed by one multiply request. It then waits for the multiplier handshake before advancing. It sits between the point-arithmetic controller (`start`/`done`) and the field squarer/multiplier datapath.

---
 rtl/ksq_sequencer.sv | 135 +++++++++++++
 tb/tb_ksq_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ksq_sequencer.sv
// ksq_sequencer: step sequencer for the repeated-squaring / multiply chain of
// a field inversion. For each ROM step it loads a square count, issues that
// many single-cycle squaring enables, requests one multiply and waits for the
// multiplier handshake before moving on to the next ROM address.
module ksq_sequencer #(
    parameter int NUM_STEPS = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [2:0]       rom_addr,
    input  logic [CNT_W-1:0] rom_data,
    output logic             sq_en,
    output logic             mul_start,
    input  logic             mul_done,
    output logic [2:0]       step
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SQR,
        S_MUL,
        S_WAIT,
        S_DONE
    } state_t;

    // Last ROM address executed; the sequence ends before the address could wrap.
    localparam logic [2:0]       LAST_STEP = 3'(NUM_STEPS);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       rom_addr_q, rom_addr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sq_en_q, sq_en_d;
    logic             mul_start_q, mul_start_d;

    // Next-state, counter and address logic; outputs are decoded from the
    // next state so that once registered they line up with the state itself.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rom_addr_d = rom_addr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    rom_addr_d = 3'd1;
                end
            end
            S_LOAD: begin
                // The ROM is combinational on the registered address, so its
                // data is valid here; a zero count skips squaring entirely.
                cnt_d = rom_data;
                if (rom_data != CNT_ZERO) begin
                    state_d = S_SQR;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_SQR: begin
                // Leaving on cnt==1 gives exactly rom_data enables, and the
                // full counter range works without an extra overflow bit.
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mul_done) begin
                    if (rom_addr_q == LAST_STEP) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_LOAD;
                        rom_addr_d = rom_addr_q + 3'd1;
                    end
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                rom_addr_d = 3'd0;
            end
            default: begin
                state_d    = S_IDLE;
                cnt_d      = CNT_ZERO;
                rom_addr_d = 3'd0;
            end
        endcase

        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        sq_en_d     = (state_d == S_SQR);
        mul_start_d = (state_d == S_MUL);
    end

    // State, counter, address and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= CNT_ZERO;
            rom_addr_q  <= 3'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sq_en_q     <= 1'b0;
            mul_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rom_addr_q  <= rom_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sq_en_q     <= sq_en_d;
            mul_start_q <= mul_start_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sq_en     = sq_en_q;
    assign mul_start = mul_start_q;
    assign rom_addr  = rom_addr_q;
    // The step index is the ROM address by construction (both are 0 in IDLE).
    assign step      = rom_addr_q;

endmodule

// File: tb/tb_ksq_sequencer.sv
// Directed testbench for ksq_sequencer: a combinational ROM model, a cycle
// monitor that records bursts, handshakes and timing of each run, and
// immediate-assertion comparisons against hand-computed values.
module tb_ksq_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mul_done;
    logic        busy;
    logic        done;
    logic        sq_en;
    logic        mul_start;
    logic [2:0]  rom_addr;
    logic [2:0]  step;
    logic [15:0] rom_data;

    logic [15:0] rom [0:7];

    int vecCount = 0;
    int errCount = 0;

    // Results recorded by one sequence run
    int         burst   [8];
    int         loadCyc [8];
    int         mulCyc  [8];
    int         mulCount;
    int         doneCount;
    int         doneCycle;
    int         relaunchCyc;
    logic       busyAfterDone;
    logic [2:0] addrTrace [$];
    bit         timedOut;
    bit         stepBad;

    ksq_sequencer #(
        .NUM_STEPS(4),
        .CNT_W    (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .sq_en    (sq_en),
        .mul_start(mul_start),
        .mul_done (mul_done),
        .step     (step)
    );

    // Combinational square-count ROM
    assign rom_data = rom[rom_addr];

    // Free-running clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        assert (observed === expected) else begin
            errCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic loadRom(input logic [15:0] c1, input logic [15:0] c2,
                           input logic [15:0] c3, input logic [15:0] c4);
        rom[0] = 16'd0;
        rom[1] = c1;
        rom[2] = c2;
        rom[3] = c3;
        rom[4] = c4;
        rom[5] = 16'd0;
        rom[6] = 16'd0;
        rom[7] = 16'd0;
    endtask

    // Runs one sequence from an idle DUT; cycle 0 is the cycle start is sampled.
    task automatic applyStimulus(input int mulDelay, input bit strayMul,
                                 input bit startPokes, input bit holdStart,
                                 input int resetAtSq);
        int         cyc;
        int         pendingDone;
        logic [2:0] prevAddr;
        bit         finished;

        for (int i = 0; i < 8; i++) begin
            burst[i]   = 0;
            loadCyc[i] = -1;
            mulCyc[i]  = -1;
        end
        mulCount      = 0;
        doneCount     = 0;
        doneCycle     = -1;
        relaunchCyc   = -1;
        busyAfterDone = 1'bx;
        addrTrace.delete();
        timedOut      = 1'b0;
        stepBad       = 1'b0;

        cyc         = 0;
        pendingDone = -1;
        prevAddr    = rom_addr;
        finished    = 1'b0;
        start       = 1'b1;
        mul_done    = 1'b0;

        while (!finished) begin
            tick();
            cyc++;
            start    = 1'b0;
            mul_done = 1'b0;

            if (rom_addr != prevAddr) begin
                addrTrace.push_back(rom_addr);
                if (rom_addr != 3'd0 && doneCycle < 0) loadCyc[rom_addr] = cyc;
                prevAddr = rom_addr;
            end
            if (doneCycle >= 0 && rom_addr == 3'd1 && relaunchCyc < 0) relaunchCyc = cyc;
            if (step !== rom_addr) stepBad = 1'b1;
            if (sq_en) burst[step]++;
            if (mul_start) begin
                mulCount++;
                mulCyc[step] = cyc;
                pendingDone  = cyc + mulDelay;
            end
            if (done) begin
                doneCount++;
                if (doneCycle < 0) doneCycle = cyc;
            end
            if (doneCycle >= 0 && cyc == doneCycle + 1) busyAfterDone = busy;

            if (cyc == pendingDone) mul_done = 1'b1;
            if (strayMul && sq_en && step == 3'd3 && burst[3] == 5) mul_done = 1'b1;
            if (startPokes && sq_en && step == 3'd2 && burst[2] == 10) start = 1'b1;
            if (startPokes && mulCyc[1] > 0 && cyc == mulCyc[1] + 1) start = 1'b1;
            if (holdStart && doneCycle >= 0 && cyc <= doneCycle + 1) start = 1'b1;

            if (resetAtSq > 0 && sq_en && step == 3'd4 && burst[4] == resetAtSq) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                checkOutput("midrst busy", busy, 0);
                checkOutput("midrst done", done, 0);
                checkOutput("midrst sq_en", sq_en, 0);
                checkOutput("midrst mul_start", mul_start, 0);
                checkOutput("midrst rom_addr", rom_addr, 0);
                checkOutput("midrst step", step, 0);
                mul_done = 1'b1;
                tick();
                mul_done = 1'b0;
                repeat (3) tick();
                checkOutput("late mul_done busy", busy, 0);
                checkOutput("late mul_done rom_addr", rom_addr, 0);
                checkOutput("late mul_done mul_start", mul_start, 0);
                finished = 1'b1;
            end

            if (doneCycle >= 0 && cyc >= doneCycle + 3) finished = 1'b1;
            if (cyc > 6000) begin
                timedOut = 1'b1;
                finished = 1'b1;
            end
        end

        start    = 1'b0;
        mul_done = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        rst      = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        mul_done = 1'b0;
        loadRom(16'd1, 16'd32, 16'd128, 16'd4096);

        // Reset values and idle with start low
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset sq_en", sq_en, 0);
        checkOutput("reset mul_start", mul_start, 0);
        checkOutput("reset rom_addr", rom_addr, 0);
        checkOutput("reset step", step, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("idle busy", busy, 0);
        end

        // Nominal sequence, multiplier answers the cycle after mul_start
        $display("[TB] nominal sequence");
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 0);
        checkOutput("nom timeout", timedOut, 0);
        checkOutput("nom burst1", burst[1], 1);
        checkOutput("nom burst2", burst[2], 32);
        checkOutput("nom burst3", burst[3], 128);
        checkOutput("nom burst4", burst[4], 4096);
        checkOutput("nom mul_start count", mulCount, 4);
        checkOutput("nom done cycle", doneCycle, 4270);
        checkOutput("nom done count", doneCount, 1);
        checkOutput("nom busy after done", busyAfterDone, 0);
        checkOutput("nom load1 cycle", loadCyc[1], 1);
        checkOutput("nom load4 cycle", loadCyc[4], 171);
        checkOutput("nom mul4 cycle", mulCyc[4], 4268);
        checkOutput("nom step tracks addr", stepBad, 0);
        checkOutput("nom addr trace len", addrTrace.size(), 5);
        if (addrTrace.size() == 5) begin
            checkOutput("nom addr[0]", addrTrace[0], 1);
            checkOutput("nom addr[1]", addrTrace[1], 2);
            checkOutput("nom addr[2]", addrTrace[2], 3);
            checkOutput("nom addr[3]", addrTrace[3], 4);
            checkOutput("nom addr[4]", addrTrace[4], 0);
        end

        // Zero square count at address 2
        $display("[TB] zero count at step 2");
        loadRom(16'd1, 16'd0, 16'd128, 16'd4096);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 0);
        checkOutput("zero timeout", timedOut, 0);
        checkOutput("zero burst1", burst[1], 1);
        checkOutput("zero burst2", burst[2], 0);
        checkOutput("zero burst3", burst[3], 128);
        checkOutput("zero burst4", burst[4], 4096);
        checkOutput("zero load2 cycle", loadCyc[2], 5);
        checkOutput("zero mul2 cycle", mulCyc[2], 6);
        checkOutput("zero mul_start count", mulCount, 4);
        checkOutput("zero done cycle", doneCycle, 4238);

        // Slow multiplier plus a stray handshake during squaring
        $display("[TB] slow multiplier with stray mul_done");
        loadRom(16'd1, 16'd32, 16'd128, 16'd4096);
        applyStimulus(5, 1'b1, 1'b0, 1'b0, 0);
        checkOutput("slow timeout", timedOut, 0);
        checkOutput("slow burst3", burst[3], 128);
        checkOutput("slow burst4", burst[4], 4096);
        checkOutput("slow mul_start count", mulCount, 4);
        checkOutput("slow wait1 span", loadCyc[2] - mulCyc[1], 6);
        checkOutput("slow done cycle", doneCycle, 4286);
        checkOutput("slow done count", doneCount, 1);

        // start pulsed while busy, then held high through DONE
        $display("[TB] start while busy and held through done");
        applyStimulus(1, 1'b0, 1'b1, 1'b1, 0);
        checkOutput("poke timeout", timedOut, 0);
        checkOutput("poke burst2", burst[2], 32);
        checkOutput("poke burst3", burst[3], 128);
        checkOutput("poke mul_start count", mulCount, 4);
        checkOutput("poke load2 cycle", loadCyc[2], 5);
        checkOutput("poke done cycle", doneCycle, 4270);
        checkOutput("poke done count", doneCount, 1);
        checkOutput("poke busy after done", busyAfterDone, 0);
        checkOutput("poke relaunch cycle", relaunchCyc, 4272);

        // Reset at the 100th squaring enable of step 4, then a fresh run
        $display("[TB] reset mid-burst");
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 100);
        checkOutput("midrst burst4", burst[4], 100);
        checkOutput("midrst no done", doneCount, 0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 0);
        checkOutput("rerun timeout", timedOut, 0);
        checkOutput("rerun burst1", burst[1], 1);
        checkOutput("rerun burst4", burst[4], 4096);
        checkOutput("rerun mul_start count", mulCount, 4);
        checkOutput("rerun done cycle", doneCycle, 4270);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
